// File: rtl/aes_pkg.sv
// Shared AES definitions for the InvSubBytes engine.
//   AES_BLOCK_W / AES_BYTE_W / SBOX_DEPTH : datapath geometry
//   isb_state_t                           : engine FSM states
//   gf_mul                                : GF(2^8) multiply, AES polynomial x^8+x^4+x^3+x+1
package aes_pkg;

    localparam int AES_BLOCK_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int SBOX_DEPTH  = 256;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_BUSY, S_DONE} isb_state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int unsigned i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_sbox.sv
// Forward AES S-box, purely combinational.
//   sbox_in  : input byte
//   sbox_out : SubBytes(sbox_in)
// Multiplicative inverse computed as x^254 by an addition chain, then the affine map.
module inv_sub_bytes_seq_sbox
    import aes_pkg::*;
(
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, x254;

    assign x2   = gf_mul(sbox_in, sbox_in);
    assign x3   = gf_mul(x2, sbox_in);
    assign x6   = gf_mul(x3, x3);
    assign x12  = gf_mul(x6, x6);
    assign x15  = gf_mul(x12, x3);
    assign x30  = gf_mul(x15, x15);
    assign x60  = gf_mul(x30, x30);
    assign x120 = gf_mul(x60, x60);
    assign x240 = gf_mul(x120, x120);
    assign x252 = gf_mul(x240, x12);
    assign x254 = gf_mul(x252, x2);

    assign sbox_out = x254
                    ^ {x254[6:0], x254[7]}
                    ^ {x254[5:0], x254[7:6]}
                    ^ {x254[4:0], x254[7:5]}
                    ^ {x254[3:0], x254[7:4]}
                    ^ 8'h63;

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// AES InvSubBytes engine. Builds its 256x8 inverse table after reset by sweeping
// the forward S-box (tbl[sbox(i)] = i), then substitutes LANES bytes per cycle.
//   clk, rst             : clock, synchronous active-high reset
//   init_done            : inverse table built
//   in_valid/in_ready    : input handshake, in_data 128-bit state
//   out_valid/out_ready  : output handshake, out_data substituted state
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic                   init_done,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_BLOCK_W-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_BLOCK_W-1:0] out_data
);

    localparam int NB = AES_BLOCK_W / AES_BYTE_W;
    localparam int N  = NB / LANES;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("inv_sub_bytes_seq: LANES must be one of 1,2,4,8,16");
    end

    isb_state_t             state_q, state_d;
    logic [7:0]             idx_q, idx_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [AES_BLOCK_W-1:0] st_q, st_d;
    logic                   init_done_q, init_done_d;

    logic [AES_BYTE_W-1:0]  tbl_q [SBOX_DEPTH];
    logic                   tbl_we;
    logic [7:0]             sbox_val;

    logic [3:0]             lane_pos [LANES];
    logic [AES_BYTE_W-1:0]  lane_sub [LANES];

    inv_sub_bytes_seq_sbox u_sbox (
        .sbox_in  (idx_q),
        .sbox_out (sbox_val)
    );

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_pos[k] = 4'(32'(cnt_q) * LANES + k);
        assign lane_sub[k] = tbl_q[st_q[AES_BYTE_W*lane_pos[k] +: AES_BYTE_W]];
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        st_d        = st_q;
        init_done_d = init_done_q;
        tbl_we      = 1'b0;
        case (state_q)
            S_INIT: begin
                tbl_we = 1'b1;
                idx_d  = idx_q + 8'd1;
                if (idx_q == 8'hff) begin
                    state_d     = S_IDLE;
                    init_done_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (in_valid) begin
                    st_d    = in_data;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int unsigned k = 0; k < LANES; k++) begin
                    st_d[AES_BYTE_W*lane_pos[k] +: AES_BYTE_W] = lane_sub[k];
                end
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'(N - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_INIT;
            idx_q       <= '0;
            cnt_q       <= '0;
            st_q        <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            st_q        <= st_d;
            init_done_q <= init_done_d;
        end
    end

    // Table has no reset: every entry is rewritten during the init sweep.
    always_ff @(posedge clk) begin
        if (tbl_we && !rst) tbl_q[sbox_val] <= idx_q;
    end

    assign init_done = init_done_q;
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign out_data  = st_q;

endmodule
